// File: rtl/sliced_logic_unit.sv
// rtl/sliced_logic_unit.sv - multi-cycle bitwise logic unit, SLICE bits per clock with start/done handshake
// Optional running-XOR accumulate mode enabled by defining SLICED_LOGIC_ACCUM_EN.
module sliced_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SLICED_LOGIC_ACCUM_EN
  input  logic             acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Res,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic             zero_q, zero_d;
  logic             keep_res;

`ifdef SLICED_LOGIC_ACCUM_EN
  logic acc_q, acc_d;
  assign keep_res = acc_q;
`else
  assign keep_res = 1'b0;
`endif

  function automatic logic [SLICE-1:0] slice_op(input logic [2:0] o,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
    case (o)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return ~(a | b);
      3'b100:  return ~(a ^ b);
      3'b101:  return ~(a & b);
      3'b110:  return a;
      default: return ~a;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
`ifdef SLICED_LOGIC_ACCUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          op_d    = op;
          cnt_d   = '0;
          zero_d  = 1'b0;
          state_d = BUSY;
`ifdef SLICED_LOGIC_ACCUM_EN
          acc_d   = acc;
          if (!acc) res_d = '0;
`else
          res_d   = '0;
`endif
        end
      end
      BUSY: begin
        // Only the slice selected by cnt_q changes; the rest of Res holds.
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) begin
            res_d[i*SLICE +: SLICE] = slice_op(op_q, a_q[i*SLICE +: SLICE], b_q[i*SLICE +: SLICE])
                                      ^ (keep_res ? res_q[i*SLICE +: SLICE] : '0);
          end
        end
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          zero_d  = (res_d == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
`ifdef SLICED_LOGIC_ACCUM_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
`ifdef SLICED_LOGIC_ACCUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign Res  = res_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_sliced_logic_unit.sv
// tb/tb_sliced_logic_unit.sv - scoreboard bench for sliced_logic_unit with a word-level reference model
module tb_sliced_logic_unit;

  logic        clk, rst, start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done, zero;
  logic [31:0] Res;
`ifdef SLICED_LOGIC_ACCUM_EN
  logic        acc_in;
`endif

  sliced_logic_unit #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
`ifdef SLICED_LOGIC_ACCUM_EN
    .acc(acc_in),
`endif
    .busy(busy), .done(done), .Res(Res), .zero(zero)
  );

  typedef struct {
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] model_res;
  int          passed = 0;
  int          total  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return ~(a ^ b);
      3'd5: return ~(a & b);
      3'd6: return a;
      default: return ~a;
    endcase
  endfunction

  // Raises start with new operands and queues the result the model predicts.
  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit ac);
    exp_t x;
    start = 1'b1; op = o; A = a; B = b;
`ifdef SLICED_LOGIC_ACCUM_EN
    acc_in = ac;
    model_res = ac ? (model_res ^ ref_op(o, a, b)) : ref_op(o, a, b);
`else
    model_res = ref_op(o, a, b) | {31'd0, ac & 1'b0};
`endif
    x.res  = model_res;
    x.zero = (model_res == 32'd0);
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      $display("FAIL %s: done timeout got busy=%b expected done=1", nm, busy);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit ac);
    @(negedge clk);
    drive(o, a, b, ac);
    @(negedge clk);
    start = 1'b0;
    wait_done("run_op");
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got Res=%h expected no done", Res);
      end else begin
        e = exp_q.pop_front();
        chk("res", Res, e.res);
        chk("zero", {31'd0, zero}, {31'd0, e.zero});
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; model_res = '0;
`ifdef SLICED_LOGIC_ACCUM_EN
    acc_in = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_res", Res, 32'd0);
    chk("rst_flags", {29'd0, busy, done, zero}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Directed XOR: watch slice 0 land first and the exact busy/done timing.
    @(negedge clk);
    drive(3'b010, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("xor_busy_k0", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("xor_busy", {31'd0, busy}, {31'd0, (k <= 4)});
      chk("xor_done", {31'd0, done}, {31'd0, (k == 4)});
      if (k == 1) chk("xor_slice0_first", Res, 32'h0000000F);
      if (k == 4) chk("xor_final", Res, 32'hF0F00F0F);
    end

    run_op(3'b000, 32'hDEADBEEF, 32'hFFFF0000, 1'b0);
    run_op(3'b011, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("res_hold", Res, 32'hFFFFFFFF);
    run_op(3'b010, 32'h12345678, 32'h12345678, 1'b0);
    @(negedge clk);
    chk("zero_hold", {31'd0, zero}, 32'd1);

    // Start raised mid-operation must wait for IDLE, then be accepted.
    @(negedge clk);
    drive(3'b010, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive(3'b000, 32'h12345678, 32'hFFFFFFFF, 1'b0);
    begin
      int n = 0;
      while (busy && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    chk("gap_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("reaccept_busy", {31'd0, busy}, 32'd1);
    wait_done("reaccept");

    // Reset during the second BUSY cycle aborts with no done pulse.
    @(negedge clk);
    drive(3'b001, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_res", Res, 32'd0);
    chk("abort_flags", {29'd0, busy, done, zero}, 32'd0);
    void'(exp_q.pop_back());
    model_res = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    run_op(3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);

`ifdef SLICED_LOGIC_ACCUM_EN
    run_op(3'b010, 32'h000000FF, 32'd0, 1'b0);
    run_op(3'b110, 32'h0000FF00, 32'd0, 1'b1);
    run_op(3'b110, 32'h0000FFFF, 32'd0, 1'b1);
`endif

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op(3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
